fg_bbox_tracker: RTL and testbench
==================================

# fg_bbox_tracker

- Streaming consumer of the background-subtraction stage's per-pixel foreground flag.
- Tracks raster position and accumulates the foreground pixel count and bounding box (x/y min/max) over one frame.
- At frame end, emits a one-cycle report for the overlay/UART reporting logic downstream.
- Sits directly after the adaptive background stage, on the same clock and pixel strobe.

## Interface
Parameters:
- IMG_W, 320, active pixels per line
- IMG_H, 240, active lines per frame
- X_W, 9, x coordinate width (must hold IMG_W-1)
- Y_W, 8, y coordinate width (must hold IMG_H-1)
- CNT_W, 17, foreground count width
- RUN_MIN, 3, minimum horizontal run length (used only with the noise filter)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  when low, all state and outputs hold and inputs are ignored
- frame_start  in  1  one-cycle pulse; marks the cycle of the frame's first pixel or an earlier cycle
- pix_valid  in  1  pixel strobe (foreground stage's delayed active)
- fg_flag  in  1  foreground decision for the current pixel
- min_count  in  CNT_W  detection threshold, sampled at report time
- box_valid  out  1  one-cycle report pulse
- box_found  out  1  count >= max(min_count,1)
- box_x_min / box_x_max  out  X_W  box columns
- box_y_min / box_y_max  out  Y_W  box rows
- box_count  out  CNT_W  foreground pixels counted in the frame
- frame_err  out  1  one-cycle pulse: frame aborted by an early frame_start

## Operation
States: IDLE, ACCUM, REPORT.

IDLE:
- pix_valid is ignored.
- frame_start clears all accumulators and sets x=y=0, then moves to ACCUM.
- A pixel sampled in the same cycle as frame_start is pixel (0,0).

ACCUM:
- Each pix_valid advances x. x wraps from IMG_W-1 to 0 and increments y.
- A counted foreground pixel increments the count (saturating at 2^CNT_W-1) and updates min/max against the pixel's (x,y).
- The pixel at (IMG_W-1, IMG_H-1) is the final pixel; after it, the state moves to REPORT.
- frame_start in ACCUM (short frame): pulse frame_err, discard accumulators, restart as if from IDLE. No report is issued.

REPORT (exactly one cycle):
- Loads the outputs and asserts box_valid, then returns to IDLE.
- If box_found=0, the box coordinates are reported as 0; box_count is always reported.
- min_count is sampled in this cycle.

Accumulator reset values:
- x_min = IMG_W-1, y_min = IMG_H-1, max = 0, count = 0.

Other rules:
- Outputs other than the pulses hold their last report until the next REPORT.
- Arithmetic is unsigned throughout. Coordinate compares are X_W/Y_W bits wide.

## Timing
- Reset: every output is 0, state is IDLE, accumulators hold their reset values.
- A reset mid-frame discards the frame and produces no report.
- Final pixel sampled at edge E: box_valid is high after edge E+1 and low after edge E+2. Report latency is 2 edges.
- Throughput: one pixel per cycle with no backpressure. pix_valid may be asserted in every cycle.
- frame_err rises one edge after the offending frame_start.
- Both pulses are gated by enable: they stretch while enable is low, and the state machine pauses.

## Configuration
BBOX_NOISE_FILTER_EN

Defined:
- A per-row run counter drops isolated foreground speckle.
- A foreground pixel counts only once the current horizontal run reaches RUN_MIN.
- On the pixel where the run reaches RUN_MIN, the count increases by RUN_MIN and x_min is compared against x-(RUN_MIN-1).
- Each further pixel in the run counts individually.
- The run resets on a non-foreground pixel and on line wrap.

Undefined:
- Every pixel with fg_flag=1 counts.
- RUN_MIN is unused.

## Structure
- Shared package bbox_pkg holds:
  - default IMG_W/IMG_H constants
  - the state typedef (IDLE/ACCUM/REPORT)
  - the coordinate/count typedefs
- Sub-module fg_run_filter contains the run counter. It outputs count_inc and x_adj, and is instantiated only under BBOX_NOISE_FILTER_EN.

## Test plan
- Empty frame, min_count=1:
  - Frame of all fg_flag=0 -> box_valid pulse 2 edges after pixel (319,239).
  - box_found=0, box_count=0, coordinates 0.
- Filled rectangle, min_count=1:
  - Rectangle x 100..149, y 50..79 in foreground -> box 100/149/50/79, box_count=1500, box_found=1.
- Threshold check, min_count=5:
  - 4 foreground pixels -> box_found=0, box_count=4.
  - Repeat with 5 pixels -> box_found=1.
- Short frame:
  - frame_start after 1000 pixels -> frame_err pulse and no box_valid.
  - Following full frame with one pixel at (0,0) -> box 0/0/0/0, count 1.
- Control hazards:
  - enable low for 10 cycles mid-frame, plus a reset at pixel 500 of another frame -> no report from the reset frame.
  - Next frame reports normally with results identical to a run without the enable gap.
- Noise filter, RUN_MIN=3, filter macro defined:
  - Isolated single/double foreground pixels plus one run at x 10..14, y=7 -> count=5, box 10/14/7/7.
  - Same stimulus without the macro -> all pixels counted.

Source files
------------

// File: rtl/bbox_pkg.sv
// Shared constants and types for the foreground bounding-box tracker.
package bbox_pkg;

  localparam int unsigned IMG_W_DEF = 320;
  localparam int unsigned IMG_H_DEF = 240;
  localparam int unsigned X_W_DEF   = 9;
  localparam int unsigned Y_W_DEF   = 8;
  localparam int unsigned CNT_W_DEF = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } bbox_state_t;

  typedef logic [X_W_DEF-1:0]   x_coord_t;
  typedef logic [Y_W_DEF-1:0]   y_coord_t;
  typedef logic [CNT_W_DEF-1:0] fg_count_t;

endpackage

// File: rtl/fg_run_filter.sv
// Horizontal run-length gate: a foreground pixel contributes only once its run
// on the current row reaches RUN_MIN; the run restarts on background and line wrap.
module fg_run_filter
  import bbox_pkg::*;
#(
  parameter int unsigned IMG_W   = IMG_W_DEF,
  parameter int unsigned X_W     = X_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned RUN_MIN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             pix,
  input  logic             fg,
  input  logic [X_W-1:0]   x,
  output logic [CNT_W-1:0] count_inc,
  output logic [X_W-1:0]   x_adj
);

  localparam int unsigned     R_W      = $clog2(RUN_MIN + 1);
  localparam logic [R_W-1:0]  RUN_SAT  = R_W'(RUN_MIN);
  localparam logic [R_W-1:0]  RUN_PRE  = R_W'(RUN_MIN - 1);
  localparam logic [X_W-1:0]  X_LAST   = X_W'(IMG_W - 1);
  localparam logic [X_W-1:0]  X_BACK   = X_W'(RUN_MIN - 1);

  logic [R_W-1:0] run_q, run_base, run_cur, run_d;

  always_comb begin
    run_base  = clear ? '0 : run_q;
    run_cur   = (run_base == RUN_SAT) ? RUN_SAT : run_base + R_W'(1);
    count_inc = '0;
    x_adj     = x;
    run_d     = run_base;
    if (pix) begin
      // The pixel that completes the run also credits the RUN_MIN-1 pixels before it.
      if (fg && run_base == RUN_PRE) begin
        count_inc = CNT_W'(RUN_MIN);
        x_adj     = x - X_BACK;
      end else if (fg && run_base == RUN_SAT) begin
        count_inc = CNT_W'(1);
      end
      run_d = (!fg || x == X_LAST) ? '0 : run_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
    end else if (enable) begin
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/fg_bbox_tracker.sv
// Per-frame foreground pixel count and bounding box with a one-cycle report.
// Define BBOX_NOISE_FILTER_EN to count only pixels in horizontal runs of RUN_MIN or more.
module fg_bbox_tracker
  import bbox_pkg::*;
#(
  parameter int unsigned IMG_W   = IMG_W_DEF,
  parameter int unsigned IMG_H   = IMG_H_DEF,
  parameter int unsigned X_W     = X_W_DEF,
  parameter int unsigned Y_W     = Y_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned RUN_MIN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic             fg_flag,
  input  logic [CNT_W-1:0] min_count,
  output logic             box_valid,
  output logic             box_found,
  output logic [X_W-1:0]   box_x_min,
  output logic [X_W-1:0]   box_x_max,
  output logic [Y_W-1:0]   box_y_min,
  output logic [Y_W-1:0]   box_y_max,
  output logic [CNT_W-1:0] box_count,
  output logic             frame_err
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  bbox_state_t state_q, state_d;

  logic [X_W-1:0]   x_q, x_min_q, x_max_q, cur_x, x_adj;
  logic [X_W-1:0]   b_x_min, b_x_max, n_x_min, n_x_max;
  logic [Y_W-1:0]   y_q, y_min_q, y_max_q, cur_y;
  logic [Y_W-1:0]   b_y_min, b_y_max, n_y_min, n_y_max;
  logic [CNT_W-1:0] count_q, count_inc, b_count, n_count, thresh;
  logic [CNT_W:0]   sum;
  logic             take, last_pix, counted, found;

  // frame_start restarts from any state, so the same-cycle pixel is (0,0)
  // and is merged into freshly cleared accumulators.
  always_comb begin
    take     = pix_valid && (frame_start || state_q == ACCUM);
    cur_x    = frame_start ? '0 : x_q;
    cur_y    = frame_start ? '0 : y_q;
    last_pix = take && (cur_x == X_LAST) && (cur_y == Y_LAST);
  end

`ifdef BBOX_NOISE_FILTER_EN
  fg_run_filter #(
    .IMG_W   (IMG_W),
    .X_W     (X_W),
    .CNT_W   (CNT_W),
    .RUN_MIN (RUN_MIN)
  ) u_run_filter (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clear     (frame_start),
    .pix       (take),
    .fg        (fg_flag),
    .x         (cur_x),
    .count_inc (count_inc),
    .x_adj     (x_adj)
  );
`else
  assign count_inc = CNT_W'(take && fg_flag);
  assign x_adj     = cur_x;
`endif

  always_comb begin
    b_x_min = frame_start ? X_LAST : x_min_q;
    b_x_max = frame_start ? '0     : x_max_q;
    b_y_min = frame_start ? Y_LAST : y_min_q;
    b_y_max = frame_start ? '0     : y_max_q;
    b_count = frame_start ? '0     : count_q;
    counted = take && (count_inc != '0);
    sum     = {1'b0, b_count} + {1'b0, count_inc};
    n_count = b_count;
    n_x_min = b_x_min;
    n_x_max = b_x_max;
    n_y_min = b_y_min;
    n_y_max = b_y_max;
    if (counted) begin
      n_count = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      if (x_adj < b_x_min) n_x_min = x_adj;
      if (cur_x > b_x_max) n_x_max = cur_x;
      if (cur_y < b_y_min) n_y_min = cur_y;
      if (cur_y > b_y_max) n_y_max = cur_y;
    end
    thresh = (min_count == '0) ? CNT_W'(1) : min_count;
    found  = (count_q >= thresh);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = ACCUM;
      ACCUM:   state_d = ACCUM;
      REPORT:  state_d = frame_start ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
    if (last_pix) state_d = REPORT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      x_min_q   <= X_LAST;
      x_max_q   <= '0;
      y_min_q   <= Y_LAST;
      y_max_q   <= '0;
      count_q   <= '0;
      box_valid <= 1'b0;
      box_found <= 1'b0;
      box_x_min <= '0;
      box_x_max <= '0;
      box_y_min <= '0;
      box_y_max <= '0;
      box_count <= '0;
      frame_err <= 1'b0;
    end else if (enable) begin
      box_valid <= (state_q == REPORT);
      frame_err <= (state_q == ACCUM) && frame_start;
      if (take) begin
        if (cur_x == X_LAST) begin
          x_q <= '0;
          y_q <= (cur_y == Y_LAST) ? '0 : cur_y + Y_W'(1);
        end else begin
          x_q <= cur_x + X_W'(1);
          y_q <= cur_y;
        end
      end else if (frame_start) begin
        x_q <= '0;
        y_q <= '0;
      end
      if (take || frame_start) begin
        count_q <= n_count;
        x_min_q <= n_x_min;
        x_max_q <= n_x_max;
        y_min_q <= n_y_min;
        y_max_q <= n_y_max;
      end
      if (state_q == REPORT) begin
        box_found <= found;
        box_count <= count_q;
        box_x_min <= found ? x_min_q : '0;
        box_x_max <= found ? x_max_q : '0;
        box_y_min <= found ? y_min_q : '0;
        box_y_max <= found ? y_max_q : '0;
      end
    end
  end

endmodule

// File: tb/tb_fg_bbox_tracker.sv
// Scoreboard bench for fg_bbox_tracker on a reduced 150x80 raster; expectations
// are hand-derived per frame and adjust when BBOX_NOISE_FILTER_EN is defined.
module tb_fg_bbox_tracker;

  localparam int unsigned W     = 150;
  localparam int unsigned H     = 80;
  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned CNT_W = 17;

  logic             clk = 1'b0;
  logic             rst, enable, frame_start, pix_valid, fg_flag;
  logic [CNT_W-1:0] min_count;
  logic             box_valid, box_found, frame_err;
  logic [X_W-1:0]   box_x_min, box_x_max;
  logic [Y_W-1:0]   box_y_min, box_y_max;
  logic [CNT_W-1:0] box_count;

  fg_bbox_tracker #(
    .IMG_W   (W),
    .IMG_H   (H),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .CNT_W   (CNT_W),
    .RUN_MIN (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .fg_flag     (fg_flag),
    .min_count   (min_count),
    .box_valid   (box_valid),
    .box_found   (box_found),
    .box_x_min   (box_x_min),
    .box_x_max   (box_x_max),
    .box_y_min   (box_y_min),
    .box_y_max   (box_y_max),
    .box_count   (box_count),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    bit found;
    int x_min, x_max, y_min, y_max, count;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input bit found, input int xn, input int xx,
                              input int yn, input int yx, input int cnt);
    exp_t e;
    e.is_err = 1'b0;
    e.found  = found;
    e.x_min  = xn;
    e.x_max  = xx;
    e.y_min  = yn;
    e.y_max  = yx;
    e.count  = cnt;
    e.cyc    = 0;
    return e;
  endfunction

  // 0 empty, 1 rectangle, 2 four-pixel run, 3 five-pixel run, 4 single (0,0), 5 noise
  function automatic logic fg_at(input int mode, input int x, input int y);
    case (mode)
      1: return x >= 100 && x <= 149 && y >= 50 && y <= 79;
      2: return y == 79 && x >= 146;
      3: return y == 79 && x >= 145;
      4: return x == 0 && y == 0;
      5: return (x == 3 && y == 2) || (x == 120 && y == 60) ||
                (y == 30 && (x == 40 || x == 41)) || (y == 20 && x >= 148) ||
                (y == 21 && x == 0) || (y == 7 && x >= 10 && x <= 14);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_frame(input int mode, input int stop_at, input int gap_at,
                             input int rst_at, input bit exp_err, input exp_t res);
    exp_t e;
    for (int p = 0; p < int'(W * H); p++) begin
      if (p == stop_at) return;
      if (p == rst_at) begin
        @(negedge clk);
        rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; fg_flag = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (p == gap_at) begin
        @(negedge clk);
        enable = 1'b0; pix_valid = 1'b1; fg_flag = 1'b1; frame_start = 1'b1;
        repeat (9) @(negedge clk);
      end
      @(negedge clk);
      enable      = 1'b1;
      frame_start = (p == 0);
      pix_valid   = 1'b1;
      fg_flag     = fg_at(mode, p % int'(W), p / int'(W));
      if (p == 0 && exp_err) begin
        e = mk(0, 0, 0, 0, 0, 0);
        e.is_err = 1'b1;
        e.cyc    = cyc + 1;
        sb.push_back(e);
      end
      if (p == int'(W * H) - 1) begin
        e = res;
        e.cyc = cyc + 2;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    pix_valid = 1'b0; frame_start = 1'b0; fg_flag = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (box_valid || frame_err) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: box_valid=%0b frame_err=%0b with nothing expected (cycle %0d)",
                 box_valid, frame_err, cyc);
      end else begin
        e = sb.pop_front();
        chk("frame_err", frame_err, e.is_err);
        chk("box_valid", box_valid, !e.is_err);
        chk("latency_cycle", cyc, e.cyc);
        if (!e.is_err) begin
          chk("box_found", box_found, e.found);
          chk("box_count", box_count, e.count);
          chk("box_x_min", box_x_min, e.x_min);
          chk("box_x_max", box_x_max, e.x_max);
          chk("box_y_min", box_y_min, e.y_min);
          chk("box_y_max", box_y_max, e.y_max);
        end
      end
    end
  end

  initial begin
    exp_t none;
    none = mk(0, 0, 0, 0, 0, 0);
    rst = 1'b1; enable = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; fg_flag = 1'b0;
    min_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_box_valid", box_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_box_found", box_found, 0);
    chk("rst_box_count", box_count, 0);
    chk("rst_box_x_min", box_x_min, 0);
    chk("rst_box_x_max", box_x_max, 0);
    chk("rst_box_y_min", box_y_min, 0);
    chk("rst_box_y_max", box_y_max, 0);
    rst = 1'b0;
    @(negedge clk);

    min_count = CNT_W'(1);
    drive_frame(0, -1, -1, -1, 0, mk(0, 0, 0, 0, 0, 0));

    // enable gap inside the rectangle frame must not change its result
    drive_frame(1, -1, 9000, -1, 0, mk(1, 100, 149, 50, 79, 1500));

    drive_frame(5, -1, -1, 500, 0, none);
    chk("midreset_box_count", box_count, 0);
    chk("midreset_box_x_max", box_x_max, 0);

    min_count = CNT_W'(5);
    drive_frame(2, -1, -1, -1, 0, mk(0, 0, 0, 0, 0, 4));
    chk("hold_box_count", box_count, 4);
    chk("hold_box_found", box_found, 0);
    drive_frame(3, -1, -1, -1, 0, mk(1, 145, 149, 79, 79, 5));

    min_count = '0;
    drive_frame(5, 1000, -1, -1, 0, none);
`ifdef BBOX_NOISE_FILTER_EN
    drive_frame(4, -1, -1, -1, 1, mk(0, 0, 0, 0, 0, 0));
`else
    drive_frame(4, -1, -1, -1, 1, mk(1, 0, 0, 0, 0, 1));
`endif

    min_count = CNT_W'(1);
`ifdef BBOX_NOISE_FILTER_EN
    drive_frame(5, -1, -1, -1, 0, mk(1, 10, 14, 7, 7, 5));
`else
    drive_frame(5, -1, -1, -1, 0, mk(1, 0, 149, 2, 60, 12));
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("pending_reports", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
